// File: rtl/mm_dot_product_stage.sv
// mm_dot_product_stage
//   AXI4-Stream compute stage for the matrix-multiplier kernel. Input packets carry
//   interleaved operand beats (A chunk, B chunk, A, B, ...). Each packet reduces to
//   one 32-bit dot product. Results are packed LANES per output beat.
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   ctrl_start           one-cycle start pulse (IDLE only), samples ctrl_num_dots
//   ctrl_num_dots        number of packets / dot products in the run
//   ctrl_done            one-cycle pulse after the final output beat is accepted
//   status_err           sticky: a packet ended on an A beat (cleared on ctrl_start)
//   s_axis_*             operand stream in (tdata lane i = bits [32i+31:32i])
//   m_axis_*             packed result stream out, tlast on the run's final beat
//   dbg_state            current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are both 1.
// The producer holds tdata/tlast stable while tvalid=1 and tready=0; tvalid never
// depends on tready.
module mm_dot_product_stage #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LANE_WIDTH       = 32,
    parameter int C_COUNT_WIDTH      = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          ctrl_start,
    input  logic [C_COUNT_WIDTH-1:0]      ctrl_num_dots,
    output logic                          ctrl_done,
    output logic                          status_err,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [1:0]                    dbg_state
);
    localparam int LANES = C_AXIS_TDATA_WIDTH / C_LANE_WIDTH;
    localparam int LW    = C_LANE_WIDTH;
    localparam int KW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                    state_q, state_d;
    logic [C_COUNT_WIDTH-1:0]      num_q;
    logic [C_COUNT_WIDTH-1:0]      pkt_cnt_q;
    logic                          parity_q;
    logic [C_AXIS_TDATA_WIDTH-1:0] a_q;
    // product stage
    logic [C_AXIS_TDATA_WIDTH-1:0] prod_q, prod_d;
    logic                          p_valid_q, p_last_q, p_flush_q, p_final_q;
    // accumulate stage
    logic [LW-1:0]                 acc_q, acc_d, sum_d;
    logic                          r_last_q, r_flush_q, r_final_q;
    // pack / output
    logic [C_AXIS_TDATA_WIDTH-1:0] pack_q;
    logic [KW-1:0]                 k_q;
    logic                          flush_q;
    logic                          m_valid_q, m_last_q;
    logic                          done_q, err_q;

    logic s_hs, m_hs, beat_last, issue, last_pkt, group_end;

    assign s_axis_tready = (state_q == ST_RUN) & ~m_valid_q & ~flush_q;
    assign s_hs          = s_axis_tvalid & s_axis_tready;
    assign m_hs          = m_valid_q & m_axis_tready;
    assign beat_last     = s_hs & s_axis_tlast;
    // A pair enters the pipeline on every B beat, and also on a tlast that lands
    // on an A beat (its missing B counts as zero, so its products are zero).
    assign issue         = s_hs & (parity_q | s_axis_tlast);
    assign last_pkt      = (pkt_cnt_q == num_q - 1'b1);
    assign group_end     = &pkt_cnt_q[KW-1:0];

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = pack_q;
    assign m_axis_tlast  = m_last_q;
    assign ctrl_done     = done_q;
    assign status_err    = err_q;
    assign dbg_state     = state_q;

    always_comb begin
        prod_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (parity_q) begin
                prod_d[i*LW +: LW] = a_q[i*LW +: LW] * s_axis_tdata[i*LW +: LW];
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + prod_q[i*LW +: LW];
        end
        // A result leaving this cycle restarts the accumulator; a pair that
        // follows immediately still lands in the fresh sum.
        acc_d = r_last_q ? '0 : acc_q;
        if (p_valid_q) begin
            acc_d = acc_d + sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ctrl_start) state_d = (ctrl_num_dots == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (beat_last && last_pkt) state_d = ST_DRAIN;
            ST_DRAIN: if (m_hs) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            pkt_cnt_q <= '0;
            parity_q  <= 1'b0;
            a_q       <= '0;
            prod_q    <= '0;
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            p_flush_q <= 1'b0;
            p_final_q <= 1'b0;
            acc_q     <= '0;
            r_last_q  <= 1'b0;
            r_flush_q <= 1'b0;
            r_final_q <= 1'b0;
            pack_q    <= '0;
            k_q       <= '0;
            flush_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_DONE);

            if (state_q == ST_IDLE && ctrl_start) begin
                num_q     <= ctrl_num_dots;
                pkt_cnt_q <= '0;
                parity_q  <= 1'b0;
                err_q     <= 1'b0;
            end

            if (s_hs) begin
                parity_q <= s_axis_tlast ? 1'b0 : ~parity_q;
                if (!parity_q) begin
                    a_q <= s_axis_tdata;
                end
                if (s_axis_tlast) begin
                    pkt_cnt_q <= pkt_cnt_q + 1'b1;
                    if (!parity_q) begin
                        err_q <= 1'b1;
                    end
                    if (group_end || last_pkt) begin
                        flush_q <= 1'b1;
                    end
                end
            end

            if (issue) begin
                prod_q <= prod_d;
            end
            p_valid_q <= issue;
            p_last_q  <= beat_last;
            p_flush_q <= beat_last & (group_end | last_pkt);
            p_final_q <= beat_last & last_pkt;

            acc_q     <= acc_d;
            r_last_q  <= p_valid_q & p_last_q;
            r_flush_q <= p_valid_q & p_flush_q;
            r_final_q <= p_valid_q & p_final_q;

            if (r_last_q) begin
                for (int i = 0; i < LANES; i++) begin
                    if (k_q == KW'(i)) begin
                        pack_q[i*LW +: LW] <= acc_q;
                    end
                end
                k_q <= k_q + 1'b1;
                if (r_flush_q) begin
                    m_valid_q <= 1'b1;
                    m_last_q  <= r_final_q;
                end
            end

            if (m_hs) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                flush_q   <= 1'b0;
                pack_q    <= '0;
                k_q       <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mm_dot_product_stage.sv
// Directed bench for mm_dot_product_stage. Expected output beats are pushed into
// exp_q as each run is set up; a monitor pops and compares on every output handshake.
module tb_mm_dot_product_stage;
  localparam int W  = 512;
  localparam int LW = 32;
  localparam int L  = W / LW;

  // ---------------- clock / reset ----------------
  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          ctrl_start = 1'b0;
  logic [31:0]   ctrl_num_dots = '0;
  logic          ctrl_done, status_err;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tlast;
  logic [1:0]    dbg_state;

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  mm_dot_product_stage dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .ctrl_start    (ctrl_start),
    .ctrl_num_dots (ctrl_num_dots),
    .ctrl_done     (ctrl_done),
    .status_err    (status_err),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [W:0] exp_q[$];   // {tlast, tdata}
  int out_beats = 0;
  int done_cnt = 0;
  int hs_cyc = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lanes(input logic [LW-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < L; i++) r[i*LW +: LW] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] lane0(input logic [LW-1:0] v);
    logic [W-1:0] r;
    r = '0;
    r[LW-1:0] = v;
    return r;
  endfunction

  // monitor: compares on handshakes, checks hold-stability while stalled
  logic       held_v = 1'b0;
  logic [W:0] held;
  always @(negedge aclk) begin
    logic [W:0] e;
    if (ctrl_done) done_cnt++;
    if (aresetn && m_axis_tvalid) begin
      if (held_v) check("hold_stable", {m_axis_tlast, m_axis_tdata}, held);
      if (m_axis_tready) begin
        out_beats++;
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {1'b0, m_axis_tdata}, {1'b0, e[W-1:0]});
          check("out_last", m_axis_tlast, e[W]);
        end
      end else begin
        held_v = 1'b1;
        held = {m_axis_tlast, m_axis_tdata};
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- driver tasks (enter/leave at posedge+1) ----------------
  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, s_axis_tready, 0);
    check({tag, "_mvalid"}, m_axis_tvalid, 0);
    check({tag, "_mdata"},  {1'b0, m_axis_tdata}, 0);
    check({tag, "_mlast"},  m_axis_tlast, 0);
    check({tag, "_done"},   ctrl_done, 0);
    check({tag, "_err"},    status_err, 0);
    check({tag, "_state"},  dbg_state, 0);
  endtask

  task automatic start_run(input logic [31:0] n);
    ctrl_num_dots = n;
    ctrl_start = 1'b1;
    @(posedge aclk); #1;
    ctrl_start = 1'b0;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic last);
    bit hs = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        hs = 1;
        hs_cyc = cyc;
      end
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!hs) check("send_timeout", 0, 1);
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    send_beat(a, 1'b0);
    send_beat(b, last);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge aclk);
      if (ctrl_done) seen = 1;
    end
    check({tag, "_done_seen"}, seen, 1);
    @(negedge aclk);
    check({tag, "_done_1cyc"}, ctrl_done, 0);
    @(posedge aclk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] e;
    int t;
    int dc;
    bit seen;

    // reset state
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_all_zero("reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // 1: single packet, 16 lanes of 2*3 -> 96, latency t+3
    exp_q.push_back({1'b1, lane0(32'd96)});
    out_beats = 0;
    start_run(1);
    send_beat(lanes(32'd2), 1'b0);
    send_beat(lanes(32'd3), 1'b1);
    t = hs_cyc;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid) seen = 1;
    end
    check("t1_latency", cyc - t, 3);
    wait_done("t1");
    check("t1_beats", out_beats, 1);

    // 2: 16 packets of two pairs, lane j = 32*(j+1)
    e = '0;
    for (int j = 0; j < 16; j++) e[j*LW +: LW] = 32 * (j + 1);
    exp_q.push_back({1'b1, e});
    out_beats = 0;
    start_run(16);
    for (int j = 0; j < 16; j++) begin
      send_pair(lanes(j + 1), lanes(32'd1), 1'b0);
      send_pair(lanes(j + 1), lanes(32'd1), 1'b1);
    end
    @(negedge aclk);
    check("t2_tready_low", s_axis_tready, 0);
    wait_done("t2");
    check("t2_beats", out_beats, 1);

    // 3: 17 packets, first output stalled 20 cycles; lane j = 16*(j+1)
    e = '0;
    for (int j = 0; j < 16; j++) e[j*LW +: LW] = 16 * (j + 1);
    exp_q.push_back({1'b0, e});
    exp_q.push_back({1'b1, lane0(32'd272)});
    out_beats = 0;
    m_axis_tready = 1'b0;
    start_run(17);
    for (int j = 0; j < 16; j++) send_pair(lanes(j + 1), lanes(32'd1), 1'b1);
    fork
      send_pair(lanes(32'd17), lanes(32'd1), 1'b1);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge aclk);
          check("t3_stall_tready", s_axis_tready, 0);
        end
        @(posedge aclk); #1;
        m_axis_tready = 1'b1;
      end
    join
    wait_done("t3");
    check("t3_beats", out_beats, 2);

    // 4: multiply wrap and accumulator wrap
    e = lane0(32'hFFFF_FFFE);
    e[LW +: LW] = 32'd3;
    exp_q.push_back({1'b1, e});
    start_run(2);
    send_pair(lane0(32'hFFFF_FFFF), lane0(32'd2), 1'b1);
    send_pair(lane0(32'h8000_0000), lane0(32'd1), 1'b0);
    send_pair(lane0(32'h8000_0000), lane0(32'd1), 1'b0);
    send_pair(lane0(32'd3), lane0(32'd1), 1'b1);
    wait_done("t4");

    // 5: packet ending on an A beat -> sticky error, result of pair 1 only
    e = lane0(32'd32);
    e[LW +: LW] = 32'd16;
    exp_q.push_back({1'b1, e});
    start_run(2);
    send_pair(lanes(32'd1), lanes(32'd2), 1'b0);
    send_beat(lanes(32'd5), 1'b1);
    @(negedge aclk);
    check("t5_err_set", status_err, 1);
    @(posedge aclk); #1;
    send_pair(lanes(32'd1), lanes(32'd1), 1'b1);
    wait_done("t5");
    check("t5_err_sticky", status_err, 1);

    // 6a: zero dots -> done 2 cycles after start, err cleared, no beats
    out_beats = 0;
    t = cyc;
    start_run(0);
    @(negedge aclk);
    check("t6_err_cleared", status_err, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge aclk);
      if (ctrl_done) seen = 1;
    end
    check("t6_done_delay", cyc - t, 2);
    repeat (3) @(negedge aclk);
    check("t6_no_beats", out_beats, 0);
    @(posedge aclk); #1;

    // 6b: beats in IDLE are refused
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    check("t6_idle_tready", s_axis_tready, 0);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;

    // 6c: reset mid-run aborts without done, then a fresh run works
    dc = done_cnt;
    start_run(3);
    send_pair(lanes(32'd1), lanes(32'd1), 1'b1);
    send_beat(lanes(32'd9), 1'b0);
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_all_zero("t6_abort");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    check("t6_no_done_on_abort", done_cnt, dc);
    exp_q.push_back({1'b1, lane0(32'd320)});
    out_beats = 0;
    start_run(1);
    send_pair(lanes(32'd4), lanes(32'd5), 1'b1);
    wait_done("t6");
    check("t6_beats", out_beats, 1);

    // final report
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mm_dot_product_stage.md
Name: mm_dot_product_stage

Overview:
- AXI4-Stream compute stage that replaces the constant adder between the AXI read master and the AXI write master in the matrix-multiplier kernel.
- Input packets carry interleaved operand beats: A-row chunk, B-column chunk, A, B, and so on.
- Each packet reduces to one 32-bit dot product.
- Results are packed 16 per 512-bit output beat for the write master.

Parameters:
C_AXIS_TDATA_WIDTH  512  stream width; must be a multiple of C_LANE_WIDTH
C_LANE_WIDTH  32  operand/result width; LANES = C_AXIS_TDATA_WIDTH/C_LANE_WIDTH (16)
C_COUNT_WIDTH  32  width of the dot-product count

Ports:
aclk  in  1  kernel clock; sole clock
aresetn  in  1  reset, synchronous, active-low
ctrl_start  in  1  one-cycle start pulse; samples ctrl_num_dots
ctrl_num_dots  in  C_COUNT_WIDTH  number of packets (dot products) in this run
ctrl_done  out  1  one-cycle pulse after the final output beat is accepted
status_err  out  1  sticky error: a packet ended on an A beat
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  C_AXIS_TDATA_WIDTH  operand lanes; lane i = bits [32i+31:32i]
s_axis_tlast  in  1  last beat of a packet (dot product)
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  output ready
m_axis_tdata  out  C_AXIS_TDATA_WIDTH  packed results
m_axis_tlast  out  1  final output beat of the run

Behaviour:
- Reset (aresetn=0 at a clock edge): state IDLE. All outputs 0: s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, ctrl_done, status_err. Accumulator, pack buffer, pipeline valids and counters are cleared.
- Reset asserted mid-run aborts the run with no ctrl_done pulse. In-flight data is discarded.
- States:
  - IDLE: on ctrl_start, go to DONE if ctrl_num_dots==0, otherwise go to RUN. status_err clears on ctrl_start. ctrl_start is ignored outside IDLE.
  - RUN: s_axis_tready = ~m_axis_tvalid & ~flush_pending.
    - Beat parity toggles per accepted beat and resets to even after tlast.
    - Even beat: latch into the A register.
    - Odd beat: issue the A and B beat pair into the pipeline.
  - RUN to DRAIN: when the tlast of packet number ctrl_num_dots is accepted.
  - DRAIN: s_axis_tready=0. Wait for the final output handshake, then go to DONE.
  - DONE: ctrl_done=1 for exactly one cycle, then IDLE.
- Pipeline:
  - Pair accepted at cycle t.
  - Cycle t+1: 16 lane products registered, each the low 32 bits of A_i*B_i.
  - Cycle t+2: acc <= acc + sum of the 16 products, all mod 2^32 (wrap, no saturation). Signed and unsigned operands give identical results.
  - If the pair ended a packet, the final acc value is written to pack lane k (k = result index mod 16) at the end of t+2. acc is cleared to 0 in the same cycle.
- Packing and output:
  - Lane k of m_axis_tdata = result k of the group.
  - Completing tlast = the tlast that yields the 16th result of a group, or the last result of the run. Accepting it sets flush_pending.
  - The output beat is presented with m_axis_tvalid=1 in cycle t+3.
  - Unfilled lanes of a partial final group are 0. m_axis_tlast=1 only on the final beat of the run.
  - m_axis_tdata and m_axis_tlast hold stable while tvalid=1 and tready=0.
  - On handshake: m_axis_tvalid drops next cycle, flush_pending clears, pack buffer is zeroed and k=0.
- Error: a tlast on an even beat sets status_err. The missing B is treated as all-zero. The packet still counts as one result.
- Input beats with tvalid=1 while IDLE or DRAIN are not accepted (tready=0).
- Output count = ceil(ctrl_num_dots/16) beats.

Test Plan:
1. num_dots=1; one packet of 2 beats, A lanes all 2, B lanes all 3 -> one output beat, lane0=96 (16*6), lanes1-15=0, tlast=1, tvalid in cycle t+3, then ctrl_done pulse.
2. num_dots=16; packet j = 4 beats: A lanes=j+1, B lanes=1, twice -> one output beat, lane j = 32*(j+1), tlast=1. tready low from the 16th tlast until the output handshake.
3. num_dots=17 with m_axis_tready held 0 for 20 cycles -> first output beat (tlast=0) held stable. Second beat: lane0 = packet-17 result, lanes1-15=0, tlast=1. Exactly 2 output beats.
4. A lane0=0xFFFFFFFF, B lane0=2, other lanes 0 -> result 0xFFFFFFFE (wrap). Acc overflow from 0x80000000*2 products -> 0.
5. Packet of 3 beats (tlast on beat 2, an A beat) -> status_err=1 and stays 1. Result = sum of pair 1 only. status_err clears at the next ctrl_start.
6. ctrl_num_dots=0 -> ctrl_done 2 cycles after ctrl_start, no output beats. aresetn=0 mid-RUN -> all outputs 0 next cycle; a new run then completes correctly.
